// File: rtl/vc_link_scheduler.sv
// Round-robin virtual-channel scheduler onto one physical link.
// Per-VC credit counters gate eligibility; the output is a single register stage.
module vc_link_scheduler #(
  parameter int VC         = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CREDITS    = 4,
  localparam int VC_W      = (VC > 1) ? $clog2(VC) : 1,
  localparam int CW        = $clog2(CREDITS + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [VC*DATA_WIDTH-1:0] in_data,
  input  logic [VC-1:0]            in_valid,
  output logic [VC-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_valid,
  output logic [VC_W-1:0]          out_vc,
  input  logic                     out_ready,
  input  logic [VC-1:0]            credit_return,
  output logic                     credit_err
);

  logic [CW-1:0]   credit [VC];
  logic [VC_W-1:0] ptr;
  logic [VC-1:0]   elig;
  logic [VC_W-1:0] cand;
  logic [VC_W-1:0] gnt;
  logic            found;
  logic            loadable;
  logic            grant;

  always_comb begin
    for (int v = 0; v < VC; v++) begin
      elig[v] = in_valid[v] && (credit[v] != '0);
    end
  end

  // Search starts one past the last grant so every VC gets a turn.
  always_comb begin
    loadable = !out_valid || out_ready;
    found    = 1'b0;
    gnt      = '0;
    cand     = '0;
    for (int i = 1; i <= VC; i++) begin
      cand = VC_W'((int'(ptr) + i) % VC);
      if (!found && elig[cand]) begin
        found = 1'b1;
        gnt   = cand;
      end
    end
    grant    = loadable && found && !rst;
    in_ready = '0;
    if (grant) in_ready[gnt] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_vc     <= '0;
      ptr        <= VC_W'(VC - 1);
      credit_err <= 1'b0;
      for (int v = 0; v < VC; v++) credit[v] <= CW'(CREDITS);
    end else begin
      if (loadable) begin
        if (grant) begin
          out_data  <= in_data[int'(gnt)*DATA_WIDTH +: DATA_WIDTH];
          out_vc    <= gnt;
          out_valid <= 1'b1;
          ptr       <= gnt;
        end else begin
          out_valid <= 1'b0;
        end
      end
      for (int v = 0; v < VC; v++) begin
        if (credit_return[v] && !(grant && gnt == VC_W'(v))) begin
          if (credit[v] == CW'(CREDITS)) credit_err <= 1'b1;
          else credit[v] <= credit[v] + 1'b1;
        end else if (!credit_return[v] && grant && gnt == VC_W'(v)) begin
          credit[v] <= credit[v] - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vc_link_scheduler.sv
// Directed testbench for vc_link_scheduler (VC=4, DATA_WIDTH=32, CREDITS=4).
// Each task drives one scenario and compares against hand-derived values.
module tb_vc_link_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] in_data;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [31:0]  out_data;
  logic         out_valid;
  logic [1:0]   out_vc;
  logic         out_ready;
  logic [3:0]   credit_return;
  logic         credit_err;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  vc_link_scheduler #(.VC(4), .DATA_WIDTH(32), .CREDITS(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_vc(out_vc), .out_ready(out_ready),
    .credit_return(credit_return), .credit_err(credit_err)
  );

  function automatic logic [31:0] mk(input int v);
    return 32'hC0DE_0000 + 32'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = '0;
    credit_return = '0;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // All VCs valid with full credits: 16 grants 0,1,2,3 x4, then stall.
  task automatic rr_16(input string tag);
    logic [3:0] exp_rdy;
    in_valid = 4'hF;
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      #1;
      exp_rdy = 4'b0001 << (k % 4);
      nvec++;
      if (in_ready !== exp_rdy) begin
        nerr++;
        $display("FAIL %s_rdy k=%0d got %b want %b", tag, k, in_ready, exp_rdy);
      end
      tick();
      nvec++;
      if (out_valid !== 1'b1 || out_vc !== 2'(k % 4) || out_data !== mk(k % 4)) begin
        nerr++;
        $display("FAIL %s_out k=%0d got v=%b vc=%0d d=%h want vc=%0d d=%h",
                 tag, k, out_valid, out_vc, out_data, k % 4, mk(k % 4));
      end
    end
    #1;
    nvec++;
    if (in_ready !== 4'b0000) begin
      nerr++;
      $display("FAIL %s_drained got %b want 0000", tag, in_ready);
    end
    tick();
    nvec++;
    if (out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL %s_idle got out_valid=%b want 0", tag, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 4'hF;
    credit_return = '0;
    out_ready = 1'b1;
    #1;
    nvec++;
    if (in_ready !== 4'b0000) begin
      nerr++;
      $display("FAIL reset_rdy got %b want 0000", in_ready);
    end
    tick();
    tick();
    nvec++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_vc !== 2'd0 || credit_err !== 1'b0) begin
      nerr++;
      $display("FAIL reset_state got v=%b d=%h vc=%0d err=%b want 0/0/0/0",
               out_valid, out_data, out_vc, credit_err);
    end
    rst = 1'b0;
    in_valid = '0;
  endtask

  task automatic test_round_robin();
    do_reset();
    rr_16("rr");
  endtask

  task automatic test_credit_stall();
    do_reset();
    in_valid = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      #1;
      nvec++;
      if (in_ready !== 4'b0100) begin
        nerr++;
        $display("FAIL stall_rdy k=%0d got %b want 0100", k, in_ready);
      end
      tick();
      nvec++;
      if (out_valid !== 1'b1 || out_vc !== 2'd2 || out_data !== mk(2)) begin
        nerr++;
        $display("FAIL stall_out k=%0d got v=%b vc=%0d d=%h", k, out_valid, out_vc, out_data);
      end
    end
    #1;
    nvec++;
    if (in_ready !== 4'b0000) begin
      nerr++;
      $display("FAIL stall_empty got %b want 0000", in_ready);
    end
    tick();
    nvec++;
    if (out_valid !== 1'b0 || out_vc !== 2'd2 || out_data !== mk(2)) begin
      nerr++;
      $display("FAIL stall_hold got v=%b vc=%0d d=%h want 0/2/%h", out_valid, out_vc, out_data, mk(2));
    end
    credit_return = 4'b0100;
    tick();
    credit_return = '0;
    nvec++;
    if (out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL ret_edge got out_valid=%b want 0", out_valid);
    end
    #1;
    nvec++;
    if (in_ready !== 4'b0100) begin
      nerr++;
      $display("FAIL ret_rdy got %b want 0100", in_ready);
    end
    tick();
    nvec++;
    if (out_valid !== 1'b1 || out_vc !== 2'd2) begin
      nerr++;
      $display("FAIL ret_flit got v=%b vc=%0d want 1/2", out_valid, out_vc);
    end
    #1;
    nvec++;
    if (in_ready !== 4'b0000) begin
      nerr++;
      $display("FAIL ret_once got %b want 0000", in_ready);
    end
    in_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    in_valid = 4'hF;
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      nvec++;
      if (in_ready !== 4'b0000) begin
        nerr++;
        $display("FAIL bp_rdy k=%0d got %b want 0000", k, in_ready);
      end
      tick();
      nvec++;
      if (out_valid !== 1'b1 || out_vc !== 2'd0 || out_data !== mk(0)) begin
        nerr++;
        $display("FAIL bp_hold k=%0d got v=%b vc=%0d d=%h want 1/0/%h",
                 k, out_valid, out_vc, out_data, mk(0));
      end
    end
    out_ready = 1'b1;
    #1;
    nvec++;
    if (in_ready !== 4'b0010) begin
      nerr++;
      $display("FAIL bp_release_rdy got %b want 0010", in_ready);
    end
    tick();
    nvec++;
    if (out_valid !== 1'b1 || out_vc !== 2'd1 || out_data !== mk(1)) begin
      nerr++;
      $display("FAIL bp_next got v=%b vc=%0d d=%h want 1/1/%h", out_valid, out_vc, out_data, mk(1));
    end
    in_valid = '0;
  endtask

  // Third grant coincides with a return: credit stays 2, so five flits total.
  task automatic test_simultaneous_return();
    do_reset();
    in_valid = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      credit_return = (k == 2) ? 4'b0010 : 4'b0000;
      #1;
      nvec++;
      if (in_ready !== 4'b0010) begin
        nerr++;
        $display("FAIL simret_rdy k=%0d got %b want 0010", k, in_ready);
      end
      tick();
    end
    credit_return = '0;
    #1;
    nvec++;
    if (in_ready !== 4'b0000) begin
      nerr++;
      $display("FAIL simret_stall got %b want 0000", in_ready);
    end
    nvec++;
    if (credit_err !== 1'b0) begin
      nerr++;
      $display("FAIL simret_err got %b want 0", credit_err);
    end
    in_valid = '0;
  endtask

  task automatic test_credit_err();
    do_reset();
    credit_return = 4'b1000;
    #1;
    nvec++;
    if (credit_err !== 1'b0) begin
      nerr++;
      $display("FAIL err_pre got %b want 0", credit_err);
    end
    tick();
    credit_return = '0;
    nvec++;
    if (credit_err !== 1'b1) begin
      nerr++;
      $display("FAIL err_set got %b want 1", credit_err);
    end
    in_valid = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      #1;
      nvec++;
      if (in_ready !== 4'b1000) begin
        nerr++;
        $display("FAIL err_cred k=%0d got %b want 1000", k, in_ready);
      end
      tick();
    end
    #1;
    nvec++;
    if (in_ready !== 4'b0000 || credit_err !== 1'b1) begin
      nerr++;
      $display("FAIL err_sticky got rdy=%b err=%b want 0000/1", in_ready, credit_err);
    end
    do_reset();
    nvec++;
    if (credit_err !== 1'b0) begin
      nerr++;
      $display("FAIL err_clear got %b want 0", credit_err);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    in_valid = 4'hF;
    tick();
    tick();
    nvec++;
    if (out_valid !== 1'b1 || out_vc !== 2'd1) begin
      nerr++;
      $display("FAIL mid_pre got v=%b vc=%0d want 1/1", out_valid, out_vc);
    end
    rst = 1'b1;
    #1;
    nvec++;
    if (in_ready !== 4'b0000) begin
      nerr++;
      $display("FAIL mid_rdy got %b want 0000", in_ready);
    end
    tick();
    rst = 1'b0;
    nvec++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_vc !== 2'd0) begin
      nerr++;
      $display("FAIL mid_flush got v=%b d=%h vc=%0d want 0/0/0", out_valid, out_data, out_vc);
    end
    rr_16("mid");
    in_valid = '0;
  endtask

  initial begin
    rst = 1'b1;
    in_data = {mk(3), mk(2), mk(1), mk(0)};
    in_valid = '0;
    out_ready = 1'b1;
    credit_return = '0;
    test_reset();
    test_round_robin();
    test_credit_stall();
    test_backpressure();
    test_simultaneous_return();
    test_credit_err();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
